// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: operation encodings,
// FSM state type and direction constants.
package shift_pkg;

  // Operation select as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_RSV = 2'b11
  } mode_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Direction input encoding.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a WIDTH-bit word for a given direction and mode.
// Rotation is built only when SHIFT_SEQ_ROTATE_EN is defined; otherwise
// every mode other than arithmetic falls through to a logical shift.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  mode_t            mode,
  output logic [WIDTH-1:0] q
);

  // Select the inserted bit from the mode; left shifts never replicate sign.
  always_comb begin
    q = '0;
    case (mode)
      MODE_ARI: begin
        if (dir == DIR_RIGHT) q = {d[WIDTH-1], d[WIDTH-1:1]};
        else                  q = {d[WIDTH-2:0], 1'b0};
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      MODE_ROT: begin
        if (dir == DIR_RIGHT) q = {d[0], d[WIDTH-1:1]};
        else                  q = {d[WIDTH-2:0], d[WIDTH-1]};
      end
`endif
      default: begin
        if (dir == DIR_RIGHT) q = {1'b0, d[WIDTH-1:1]};
        else                  q = {d[WIDTH-2:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Optional rotate mode is enabled by defining SHIFT_SEQ_ROTATE_EN.
//
// Handshake: start is sampled only in IDLE; busy is high in SHIFT and DONE;
// done pulses for one cycle with the result on dout, which then holds until
// the next accepted start. Starts while busy are dropped, never queued.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [SH_W-1:0]  sh,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int LOG_W = $clog2(WIDTH);
  // Counter must hold WIDTH itself for saturated shifts.
  localparam int CNT_W = LOG_W + 1;
  localparam logic [SH_W:0]    WIDTH_SH  = (SH_W + 1)'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              dir_q;
  mode_t             mode_q;
  mode_t             mode_in;
  logic [CNT_W-1:0]  k;
  logic [WIDTH-1:0]  step_q;

  // Normalise the requested mode; reserved (and rotate when absent) act logical.
  always_comb begin
    mode_in = MODE_LOG;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (mode_t'(mode) == MODE_ARI || mode_t'(mode) == MODE_ROT) mode_in = mode_t'(mode);
`else
    if (mode_t'(mode) == MODE_ARI) mode_in = MODE_ARI;
`endif
  end

  // Effective shift count: saturate at WIDTH, or wrap modulo WIDTH for rotate.
  // Shifting WIDTH times one position naturally yields the saturated value.
  always_comb begin
    k = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (mode_in == MODE_ROT)          k = CNT_W'(sh[LOG_W-1:0]);
    else
`endif
    if ({1'b0, sh} >= WIDTH_SH)       k = WIDTH_CNT;
    else                              k = CNT_W'(sh);
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d    (dout),
    .dir  (dir_q),
    .mode (mode_q),
    .q    (step_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (k == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
    done = (state == DONE);
  end

  // Working register, counter and latched command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      cnt    <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_LOG;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dout   <= din;
            dir_q  <= dir;
            mode_q <= mode_in;
            cnt    <= k;
          end
        end
        SHIFT: begin
          dout <= step_q;
          cnt  <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
